// File: rtl/mips_pipe_pkg.sv
// Shared pipeline constants: Tuse/Tnew encodings and mult/div latencies.
// The hazard and decoder blocks both import this package.
package mips_pipe_pkg;

  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W_DEF       = 4;

  // TUSE_NONE (3) can never be below a legal tnew, so unused sources fall out naturally.
  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] dst, input logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Hazard bundle between the pipeline datapath (master) and the stall controller (slave).
interface hazard_stall_controller_if;

  logic [4:0]  rs_D;
  logic [4:0]  rt_D;
  logic [1:0]  tuse_rs_D;
  logic [1:0]  tuse_rt_D;
  logic [4:0]  WriteReg_E;
  logic [1:0]  tnew_E;
  logic [4:0]  WriteReg_M;
  logic [1:0]  tnew_M;
  logic        md_op_D;
  logic        md_start_E;
  logic        md_is_div_E;
  logic        stall;
  logic        flush_E;
  logic        md_busy;
  logic [31:0] stall_count;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, WriteReg_E, tnew_E, WriteReg_M, tnew_M,
    output md_op_D, md_start_E, md_is_div_E,
    input  stall, flush_E, md_busy, stall_count
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, WriteReg_E, tnew_E, WriteReg_M, tnew_M,
    input  md_op_D, md_start_E, md_is_div_E,
    output stall, flush_E, md_busy, stall_count
  );

endinterface

// File: rtl/hazard_stall_controller_md_busy_counter.sv
// Mult/div occupancy counter: loads the op latency on start, counts down to idle.
module md_busy_counter
  import mips_pipe_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // A start while busy simply reloads; upstream stalls keep that from happening.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush controller: Tuse/Tnew data hazards, mult/div occupancy,
// and a free-running count of stalled cycles.
module hazard_stall_controller
  import mips_pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input logic                     CLK,
  input logic                     RESET,
  hazard_stall_controller_if.slave hz
);

  logic        data_stall;
  logic        md_stall;
  logic        md_busy;
  logic        stall;
  logic [31:0] stall_count_d, stall_count_q;

  md_busy_counter #(
    .CNT_W      (CNT_W),
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .start_i (hz.md_start_E),
    .is_div_i(hz.md_is_div_E),
    .busy_o  (md_busy)
  );

  always_comb begin
    data_stall = src_hazard(hz.rs_D, hz.tuse_rs_D, hz.WriteReg_E, hz.tnew_E)
               | src_hazard(hz.rs_D, hz.tuse_rs_D, hz.WriteReg_M, hz.tnew_M)
               | src_hazard(hz.rt_D, hz.tuse_rt_D, hz.WriteReg_E, hz.tnew_E)
               | src_hazard(hz.rt_D, hz.tuse_rt_D, hz.WriteReg_M, hz.tnew_M);
    md_stall   = hz.md_op_D & (md_busy | hz.md_start_E);
    // Reset masks the stall so the pipeline registers clear cleanly.
    stall      = (data_stall | md_stall) & ~RESET;
  end

  assign stall_count_d = stall_count_q + 32'(stall);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign hz.stall       = stall;
  assign hz.flush_E     = stall;
  assign hz.md_busy     = md_busy;
  assign hz.stall_count = stall_count_q;

endmodule
